// File: rtl/llc_repl_pkg.sv
// Shared types for the LLC tree-PLRU replacement path: line state, request ops,
// and the default associativity plus tree width.
package llc_repl_pkg;

    localparam int N_WAY  = 16;
    localparam int PLRU_W = N_WAY - 1;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_e;

    typedef enum logic [1:0] {
        OP_TOUCH = 2'b00,
        OP_FILL  = 2'b01,
        OP_QUERY = 2'b10,
        OP_RSVD  = 2'b11
    } repl_op_e;

endpackage

// File: rtl/llc_plru_core.sv
// Combinational tree-PLRU kernel: victim pick (invalid ways first, then tree walk)
// and path update toward the touched or chosen way.
module llc_plru_core
    import llc_repl_pkg::*;
#(
    parameter int N_WAY = 16,
    parameter int WAY_W = $clog2(N_WAY)
) (
    input  logic [N_WAY-2:0]   tree,
    input  logic [1:0]         op,
    input  logic [WAY_W-1:0]   way,
    input  logic [2*N_WAY-1:0] mesi,
    output logic [N_WAY-2:0]   tree_nxt,
    output logic [WAY_W-1:0]   rsp_way,
    output logic               from_invalid,
    output logic               err
);

    logic             inv_hit;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] walk_way;
    logic [WAY_W-1:0] sel_way;
    logic [WAY_W-1:0] upd_way;
    logic             upd;

    always_comb begin
        int node;
        inv_hit  = 1'b0;
        inv_way  = '0;
        walk_way = '0;
        // Downward scan leaves the lowest invalid way as the final winner.
        for (int w = N_WAY - 1; w >= 0; w--) begin
            if (mesi[2*w +: 2] == MESI_I) begin
                inv_hit = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            walk_way[WAY_W-1-l] = ~tree[node];
            node = 2 * node + (tree[node] ? 1 : 2);
        end
        sel_way = inv_hit ? inv_way : walk_way;
    end

    always_comb begin
        int node;
        rsp_way      = '0;
        from_invalid = 1'b0;
        err          = 1'b0;
        upd          = 1'b0;
        upd_way      = '0;
        tree_nxt     = tree;
        case (repl_op_e'(op))
            OP_TOUCH: begin
                rsp_way = way;
                upd     = 1'b1;
                upd_way = way;
            end
            OP_FILL: begin
                rsp_way      = sel_way;
                from_invalid = inv_hit;
                upd          = 1'b1;
                upd_way      = sel_way;
            end
            OP_QUERY: begin
                rsp_way      = sel_way;
                from_invalid = inv_hit;
            end
            default: err = 1'b1;
        endcase
        node = 0;
        if (upd) begin
            for (int l = 0; l < WAY_W; l++) begin
                tree_nxt[node] = upd_way[WAY_W-1-l];
                node = 2 * node + (upd_way[WAY_W-1-l] ? 2 : 1);
            end
        end
    end

endmodule

// File: rtl/llc_repl_ctrl.sv
// Per-set PLRU state owner: INIT sweep zeroes all trees, then a 2-stage
// read / compute+writeback pipeline serves TOUCH, FILL and QUERY requests.
module llc_repl_ctrl
    import llc_repl_pkg::*;
#(
    parameter int N_WAY = llc_repl_pkg::N_WAY,
    parameter int N_SET = 1024,
    parameter int SET_W = $clog2(N_SET),
    parameter int WAY_W = $clog2(N_WAY)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [SET_W-1:0]   req_set,
    input  logic [WAY_W-1:0]   req_way,
    input  logic [2*N_WAY-1:0] req_mesi,
    output logic               rsp_valid,
    output logic [SET_W-1:0]   rsp_set,
    output logic [WAY_W-1:0]   rsp_way,
    output logic               rsp_from_invalid,
    output logic               rsp_err
);

    localparam int TW = N_WAY - 1;

    if (N_WAY < 2 || (N_WAY & (N_WAY - 1)) != 0) begin : g_bad_nway
        $error("llc_repl_ctrl: N_WAY must be a power of two >= 2");
    end
    if (N_SET < 2 || (N_SET & (N_SET - 1)) != 0) begin : g_bad_nset
        $error("llc_repl_ctrl: N_SET must be a power of two >= 2");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e             state_q, state_d;
    logic [SET_W-1:0]   init_cnt;
    logic [TW-1:0]      tree_mem [N_SET];
    logic [2:1]         vld_pipe;
    logic               accept;

    logic [1:0]         s1_op, s2_op;
    logic [SET_W-1:0]   s1_set, s2_set;
    logic [WAY_W-1:0]   s1_way, s2_way;
    logic [2*N_WAY-1:0] s1_mesi, s2_mesi;
    logic [TW-1:0]      s2_tree;
    logic               s2_wr;

    logic [TW-1:0]      c_tree_nxt;
    logic [WAY_W-1:0]   c_way;
    logic               c_inv, c_err;

    logic               mem_we;
    logic [SET_W-1:0]   mem_wa;
    logic [TW-1:0]      mem_wd;

    assign req_ready = (state_q == ST_RUN) && !rst;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_cnt == SET_W'(N_SET - 1)) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    assign s2_wr = vld_pipe[2] && (s2_op == OP_TOUCH || s2_op == OP_FILL);

    always_comb begin
        mem_we = 1'b0;
        mem_wa = s2_set;
        mem_wd = c_tree_nxt;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_we = 1'b1;
                mem_wa = init_cnt;
                mem_wd = '0;
            end else begin
                mem_we = s2_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) tree_mem[mem_wa] <= mem_wd;
    end

    // The S2 write lands on the same edge S1 reads; forward it so a back-to-back
    // same-set request sees the fresh tree rather than the stale array word.
    always_ff @(posedge clk) begin
        s1_op   <= req_op;
        s1_set  <= req_set;
        s1_way  <= req_way;
        s1_mesi <= req_mesi;
        s2_op   <= s1_op;
        s2_set  <= s1_set;
        s2_way  <= s1_way;
        s2_mesi <= s1_mesi;
        s2_tree <= (s2_wr && s2_set == s1_set) ? c_tree_nxt : tree_mem[s1_set];
    end

    llc_plru_core #(.N_WAY(N_WAY), .WAY_W(WAY_W)) u_core (
        .tree         (s2_tree),
        .op           (s2_op),
        .way          (s2_way),
        .mesi         (s2_mesi),
        .tree_nxt     (c_tree_nxt),
        .rsp_way      (c_way),
        .from_invalid (c_inv),
        .err          (c_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe         <= '0;
            rsp_valid        <= 1'b0;
            rsp_set          <= '0;
            rsp_way          <= '0;
            rsp_from_invalid <= 1'b0;
            rsp_err          <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[1], accept};
            rsp_valid <= vld_pipe[2];
            if (vld_pipe[2]) begin
                rsp_set          <= s2_set;
                rsp_way          <= c_way;
                rsp_from_invalid <= c_inv;
                rsp_err          <= c_err;
            end
        end
    end

endmodule

// File: tb/tb_llc_repl_ctrl.sv
// Self-checking bench for llc_repl_ctrl: directed scenarios plus random traffic
// scored against a serial PLRU reference model.
module tb_llc_repl_ctrl;
    import llc_repl_pkg::*;

    localparam int NW = 16;
    localparam int WW = 4;
    localparam int NS = 64;
    localparam int SW = 6;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [SW-1:0]   req_set;
    logic [WW-1:0]   req_way;
    logic [2*NW-1:0] req_mesi;
    logic            rsp_valid;
    logic [SW-1:0]   rsp_set;
    logic [WW-1:0]   rsp_way;
    logic            rsp_from_invalid;
    logic            rsp_err;

    llc_repl_ctrl #(.N_WAY(NW), .N_SET(NS)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_set          (req_set),
        .req_way          (req_way),
        .req_mesi         (req_mesi),
        .rsp_valid        (rsp_valid),
        .rsp_set          (rsp_set),
        .rsp_way          (rsp_way),
        .rsp_from_invalid (rsp_from_invalid),
        .rsp_err          (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         set;
        int         way;
        int         inv;
        int         err;
    } exp_t;

    int              total = 0;
    int              bad   = 0;
    int              cyc   = 0;
    int              init_left = 0;
    bit              armed = 0;
    bit              last_ready;
    logic [NW-2:0]   mtree [NS];
    exp_t            expq [$];
    int              seen_way [$];
    int              seen_inv [$];
    int              seen_err [$];
    logic [2*NW-1:0] allv;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Level-order view of the tree: the node at depth l on the path to w is
    // (2^l - 1) plus the l leading bits of w.
    function automatic int node_of(input int lvl, input int prefix);
        return (1 << lvl) - 1 + prefix;
    endfunction

    function automatic void m_apply(input int set, input int w);
        for (int l = 0; l < WW; l++)
            mtree[set][node_of(l, w >> (WW - l))] = 1'((w >> (WW - 1 - l)) & 1);
    endfunction

    function automatic int m_walk(input int set);
        int v = 0;
        for (int l = 0; l < WW; l++)
            v = 2 * v + (mtree[set][node_of(l, v)] ? 0 : 1);
        return v;
    endfunction

    task automatic model_accept();
        exp_t e;
        int   lo;
        e.due = cyc + 3;
        e.set = int'(req_set);
        e.way = 0; e.inv = 0; e.err = 0;
        lo = -1;
        for (int w = NW - 1; w >= 0; w--)
            if (req_mesi[2*w +: 2] == 2'b00) lo = w;
        case (req_op)
            2'd0: begin e.way = int'(req_way); m_apply(e.set, e.way); end
            2'd1, 2'd2: begin
                if (lo >= 0) begin e.way = lo; e.inv = 1; end
                else e.way = m_walk(e.set);
                if (req_op == 2'd1) m_apply(e.set, e.way);
            end
            default: e.err = 1;
        endcase
        expq.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        int   exp_rdy;
        @(negedge clk);
        exp_rdy = 0;
        if (armed) begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                e = expq.pop_front();
                chk("rsp_valid", int'(rsp_valid), 1);
                chk("rsp_set", int'(rsp_set), e.set);
                chk("rsp_way", int'(rsp_way), e.way);
                chk("rsp_from_invalid", int'(rsp_from_invalid), e.inv);
                chk("rsp_err", int'(rsp_err), e.err);
                seen_way.push_back(int'(rsp_way));
                seen_inv.push_back(int'(rsp_from_invalid));
                seen_err.push_back(int'(rsp_err));
            end else begin
                chk("rsp_idle", int'(rsp_valid), 0);
            end
            exp_rdy = (!rst && init_left == 0) ? 1 : 0;
            chk("req_ready", int'(req_ready), exp_rdy);
            if (req_valid && exp_rdy == 1) model_accept();
        end
        last_ready = req_ready;
        if (rst) begin
            expq.delete();
            for (int s = 0; s < NS; s++) mtree[s] = '0;
            init_left = NS;
            armed = 1;
        end else if (init_left > 0) begin
            init_left--;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input int op, input int set, input int way, input logic [2*NW-1:0] m);
        req_valid = 1'b1;
        req_op    = 2'(op);
        req_set   = SW'(set);
        req_way   = WW'(way);
        req_mesi  = m;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_seen();
        seen_way.delete(); seen_inv.delete(); seen_err.delete();
    endtask

    task automatic chk_seen(input string tag, input int idx, input int way, input int inv, input int err);
        if (seen_way.size() <= idx) begin
            chk({tag, "_count"}, seen_way.size(), idx + 1);
        end else begin
            chk({tag, "_way"}, seen_way[idx], way);
            chk({tag, "_inv"}, seen_inv[idx], inv);
            chk({tag, "_err"}, seen_err[idx], err);
        end
    endtask

    initial begin
        logic [2*NW-1:0] m;
        int n;
        for (int w = 0; w < NW; w++) allv[2*w +: 2] = 2'b10;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_set = '0; req_way = '0; req_mesi = allv;
        idle(3);
        rst = 1'b0;

        // init length, then first QUERY on set 0
        req_valid = 1'b1; req_op = 2'd2; req_set = '0; req_mesi = allv;
        n = 0;
        clear_seen();
        tick();
        while (!last_ready && n < NS + 10) begin
            n++;
            tick();
        end
        req_valid = 1'b0;
        chk("init_len", n, NS);
        idle(4);
        chk_seen("t1", 0, 15, 0, 0);

        clear_seen();
        issue(1, 7, 0, allv); issue(1, 7, 0, allv); idle(1); issue(1, 7, 0, allv); idle(4);
        chk_seen("t2a", 0, 15, 0, 0); chk_seen("t2b", 1, 7, 0, 0); chk_seen("t2c", 2, 11, 0, 0);

        clear_seen();
        issue(0, 3, 5, allv); issue(2, 3, 0, allv); issue(2, 3, 0, allv); idle(4);
        chk_seen("t3a", 0, 5, 0, 0); chk_seen("t3b", 1, 15, 0, 0); chk_seen("t3c", 2, 15, 0, 0);

        clear_seen();
        m = allv; m[7:6] = 2'b00; m[19:18] = 2'b00;
        issue(1, 9, 0, m); issue(1, 9, 0, allv); idle(4);
        chk_seen("t4a", 0, 3, 1, 0); chk_seen("t4b", 1, 15, 0, 0);

        clear_seen();
        issue(3, 2, 6, allv); issue(2, 2, 0, allv); idle(4);
        chk_seen("t5a", 0, 0, 0, 1); chk_seen("t5b", 1, 15, 0, 0);

        clear_seen();
        issue(1, 11, 0, allv); issue(1, 11, 0, allv);
        rst = 1'b1; idle(1); rst = 1'b0;
        idle(NS + 2);
        chk("t6_dropped", seen_way.size(), 0);
        issue(2, 11, 0, allv); idle(4);
        chk_seen("t6", 0, 15, 0, 0);

        for (int i = 0; i < 400; i++) begin
            m = '0;
            for (int w = 0; w < NW; w++)
                m[2*w +: 2] = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            req_valid = ($urandom_range(0, 9) < 7);
            req_op    = 2'($urandom_range(0, 3));
            req_set   = SW'($urandom_range(0, 3));
            req_way   = WW'($urandom_range(0, NW - 1));
            req_mesi  = m;
            tick();
        end
        idle(5);
        chk("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
